// File: rtl/des_perm_if.sv
// Handshake bundle between des_perm_engine and its producer/consumer.
// DES_PERM_SWAP_EN adds the in_swap sideband sampled with in_data.
interface des_perm_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_mode;
`ifdef DES_PERM_SWAP_EN
  logic        in_swap;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

`ifdef DES_PERM_SWAP_EN
  modport master (output in_valid, in_data, in_mode, in_swap, out_ready,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  in_valid, in_data, in_mode, in_swap, out_ready,
                  output in_ready, out_valid, out_data, busy);
`else
  modport master (output in_valid, in_data, in_mode, out_ready,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  in_valid, in_data, in_mode, out_ready,
                  output in_ready, out_valid, out_data, busy);
`endif
endinterface

// File: rtl/des_perm_engine.sv
// Multi-cycle DES IP / FP permutation producing BITS_PER_CYCLE result bits per clock.
// Optional macro DES_PERM_SWAP_EN adds in_swap (exchange 32-bit halves before permuting).
module des_perm_engine #(
  parameter int unsigned BITS_PER_CYCLE = 8,
  parameter bit          OUT_HOLD_CLR   = 1'b1
) (
  input logic       clk,
  input logic       rst,
  des_perm_if.slave bus
);
  localparam int unsigned N  = 64 / BITS_PER_CYCLE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  // DES bit numbers, MSB-first: entry i is the source bit for output bit i+1
  localparam int unsigned IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
  localparam int unsigned FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  generate
    if (!(BITS_PER_CYCLE == 1  || BITS_PER_CYCLE == 2  || BITS_PER_CYCLE == 4 ||
          BITS_PER_CYCLE == 8  || BITS_PER_CYCLE == 16 || BITS_PER_CYCLE == 32 ||
          BITS_PER_CYCLE == 64)) begin : g_bad_bits_per_cycle
      $error("des_perm_engine: BITS_PER_CYCLE must be a power of two from 1 to 64");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, PERM, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [63:0]     held;
  logic            held_mode;
  logic [63:0]     data;
  logic [63:0]     data_next;
  logic [63:0]     perm_full;
  logic [63:0]     blk_in;
  logic            accept;
  logic            ready;
  logic            last;

`ifdef DES_PERM_SWAP_EN
  assign blk_in = bus.in_swap ? {bus.in_data[31:0], bus.in_data[63:32]} : bus.in_data;
`else
  assign blk_in = bus.in_data;
`endif

  assign last          = (cnt == CW'(N - 1));
  assign bus.in_ready  = ready;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = PERM;
        end
      end
      PERM: if (last) state_next = DONE;
      DONE: begin
        ready = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            accept     = 1'b1;
            state_next = PERM;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    perm_full = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      perm_full[6'(63 - i)] = held[6'(64 - (held_mode ? FP_TBL[i] : IP_TBL[i]))];
    end
  end

  // Only the slice addressed by cnt is refreshed; the rest of data is carried over.
  always_comb begin
    data_next = data;
    for (int unsigned j = 0; j < 64; j++) begin
      if (CW'(j / BITS_PER_CYCLE) == cnt) data_next[6'(63 - j)] = perm_full[6'(63 - j)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held      <= '0;
      held_mode <= 1'b0;
      cnt       <= '0;
      data      <= '0;
    end else begin
      if (accept) begin
        held      <= blk_in;
        held_mode <= bus.in_mode;
        cnt       <= '0;
      end else if (state == PERM && !last) begin
        cnt <= cnt + CW'(1);
      end
      if (state == PERM)
        data <= data_next;
      else if (state == DONE && bus.out_ready && OUT_HOLD_CLR)
        data <= '0;
    end
  end
endmodule
